// File: rtl/pbdebounce_array.sv
// pbdebounce_array: N-channel push-button conditioner.
// One shared sample tick drives every channel's 2-FF synchroniser, debounce
// counter and long-press/auto-repeat state machine. All outputs are flops.
// The release strobe port is called release_o because "release" is a
// reserved word in SystemVerilog.
module pbdebounce_array #(
  parameter int N            = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int STABLE_TICKS = 8,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] button,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_o,
  output logic [N-1:0] hold,
  output logic         tick
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
  localparam int HC_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_REPEAT = 2'd2,
    S_DONE   = 2'd3
  } hold_state_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [N-1:0]     sync1_q, sync1_d;
  logic [N-1:0]     sync_q, sync_d;
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     press_q, press_d;
  logic [N-1:0]     rel_q, rel_d;
  logic [N-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [HC_W-1:0]  hc_q [N];
  logic [HC_W-1:0]  hc_d [N];
  hold_state_e      st_q [N];
  hold_state_e      st_d [N];

  // Tick divider: counts 0..DIV-1; the tick flop is set in the cycle the count sits at DIV-1.
  always_comb begin
    div_d  = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_W'(DIV - 1));
  end

  // Two-stage synchroniser for the raw buttons.
  always_comb begin
    sync1_d = button;
    sync_d  = sync1_q;
  end

  // Per-channel debounce and hold FSM; everything advances only on the edge that raises tick.
  always_comb begin : ch_next
    logic lvl_n;
    logic prs_n;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    hold_d  = '0;
    lvl_n   = 1'b0;
    prs_n   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      hc_d[i]  = hc_q[i];
      st_d[i]  = st_q[i];
      lvl_n    = level_q[i];
      prs_n    = 1'b0;
      if (tick_d) begin
        // Any sample agreeing with the current level restarts the count.
        if (sync_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (int'(cnt_q[i]) + 1 >= STABLE_TICKS) begin
          lvl_n    = sync_q[i];
          cnt_d[i] = '0;
          prs_n    = sync_q[i];
          rel_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        press_d[i] = prs_n;
        level_d[i] = lvl_n;

        // Release wins over any pending hold strobe in the same tick.
        if (!lvl_n) begin
          st_d[i] = S_IDLE;
          hc_d[i] = '0;
        end else if (prs_n) begin
          st_d[i] = S_ARM;
          hc_d[i] = '0;
        end else begin
          case (st_q[i])
            S_ARM: begin
              if (int'(hc_q[i]) + 1 >= HOLD_TICKS) begin
                hold_d[i] = 1'b1;
                hc_d[i]   = '0;
                st_d[i]   = (REPEAT_TICKS == 0) ? S_DONE : S_REPEAT;
              end else begin
                hc_d[i] = hc_q[i] + HC_W'(1);
              end
            end
            S_REPEAT: begin
              if (int'(hc_q[i]) + 1 >= REPEAT_TICKS) begin
                hold_d[i] = 1'b1;
                hc_d[i]   = '0;
              end else begin
                hc_d[i] = hc_q[i] + HC_W'(1);
              end
            end
            default: begin
              st_d[i] = st_q[i];
            end
          endcase
        end
      end
    end
  end

  // State registers; asynchronous reset clears every flop including mid-count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= '0;
      sync_q  <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      hold_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
        hc_q[i]  <= '0;
        st_q[i]  <= S_IDLE;
      end
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      sync1_q <= sync1_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
        hc_q[i]  <= hc_d[i];
        st_q[i]  <= st_d[i];
      end
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = rel_q;
  assign hold      = hold_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_pbdebounce_array.sv
// Testbench for pbdebounce_array: two instances (auto-repeat on and off)
// share clock, reset and buttons and are compared every cycle against a
// tick-level reference model, plus directed timing checks.
`timescale 1ns/1ps
module tb_pbdebounce_array;

  localparam int DIV  = 10;
  localparam int ST   = 4;
  localparam int HOLD = 6;
  localparam int REPA = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] button = 2'b00;
  logic [1:0] lvl_a, prs_a, rel_a, hld_a;
  logic [1:0] lvl_b, prs_b, rel_b, hld_b;
  logic       tck_a, tck_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  pbdebounce_array #(.N(2), .CLK_HZ(10), .TICK_HZ(1), .STABLE_TICKS(ST),
                     .HOLD_TICKS(HOLD), .REPEAT_TICKS(REPA)) dut_a (
    .clk(clk), .rst_n(rst_n), .button(button), .level(lvl_a), .press(prs_a),
    .release_o(rel_a), .hold(hld_a), .tick(tck_a));

  pbdebounce_array #(.N(2), .CLK_HZ(10), .TICK_HZ(1), .STABLE_TICKS(ST),
                     .HOLD_TICKS(HOLD), .REPEAT_TICKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .button(button), .level(lvl_b), .press(prs_b),
    .release_o(rel_b), .hold(hld_b), .tick(tck_b));

  always #5 clk = ~clk;

  // Reference model state: edges since reset, recent tick samples per channel.
  int          m_edges;
  int          m_tickn;
  bit   [1:0]  m_s1, m_s, m_lvl;
  logic [31:0] m_hist [2];
  int          m_nsince [2];
  int          m_ptick [2];
  bit          m_tick;
  bit   [1:0]  m_prs, m_rel, m_hld_a, m_hld_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_tickn = 0;
    m_s1 = '0; m_s = '0; m_lvl = '0;
    m_tick = 1'b0; m_prs = '0; m_rel = '0; m_hld_a = '0; m_hld_b = '0;
    for (int c = 0; c < 2; c++) begin
      m_hist[c] = '0; m_nsince[c] = 0; m_ptick[c] = 0;
    end
  endtask

  // One clock edge of the reference: a level flips once the last ST tick
  // samples taken since the previous flip all disagree with it; hold strobes
  // fall at HOLD ticks after the press and every REPA ticks thereafter.
  task automatic model_step();
    int e;
    m_edges++;
    m_tick = ((m_edges % DIV) == DIV - 1);
    m_prs = '0; m_rel = '0; m_hld_a = '0; m_hld_b = '0;
    if (m_tick) begin
      m_tickn++;
      for (int c = 0; c < 2; c++) begin
        m_hist[c] = {m_hist[c][30:0], m_s[c]};
        m_nsince[c]++;
        if (m_nsince[c] >= ST && m_hist[c][ST-1:0] == {ST{~m_lvl[c]}}) begin
          m_lvl[c] = ~m_lvl[c];
          m_nsince[c] = 0;
          if (m_lvl[c]) begin
            m_prs[c] = 1'b1;
            m_ptick[c] = m_tickn;
          end else begin
            m_rel[c] = 1'b1;
          end
        end else if (m_lvl[c]) begin
          e = m_tickn - m_ptick[c];
          m_hld_a[c] = (e == HOLD) || (e > HOLD && ((e - HOLD) % REPA) == 0);
          m_hld_b[c] = (e == HOLD);
        end
      end
    end
    m_s  = m_s1;
    m_s1 = button;
  endtask

  task automatic check_all();
    chk("tick_a", tck_a, m_tick);
    chk("tick_b", tck_b, m_tick);
    chk("level_a", lvl_a, m_lvl);
    chk("level_b", lvl_b, m_lvl);
    chk("press_a", prs_a, m_prs);
    chk("press_b", prs_b, m_prs);
    chk("release_a", rel_a, m_rel);
    chk("release_b", rel_b, m_rel);
    chk("hold_a", hld_a, m_hld_a);
    chk("hold_b", hld_b, m_hld_b);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) model_step();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse starting away from a clock edge.
  task automatic pulse_reset(input int cycles);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  int first_tick, tcyc, lat, pc, nh_a, nh_b, late, seen_rel, npress, nhold, rate;
  int h [3];

  initial begin
    model_reset();
    // Reset held with both buttons down: everything stays zero.
    button = 2'b11;
    #2;
    check_all();
    repeat (3) step();
    rst_n = 1'b1;
    button = 2'b00;
    // The cycle containing reset release is cycle 1.
    first_tick = -1;
    tcyc = 1;
    for (int k = 0; k < 3 * DIV && first_tick < 0; k++) begin
      step();
      tcyc++;
      if (tck_a) first_tick = tcyc;
    end
    chk("first_tick_cycle", first_tick, DIV);
    repeat (25) step();

    // Clean press and release on channel 0.
    button[0] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      step();
      if (prs_a[0]) lat = k;
    end
    chk("press_latency_ok", (lat >= (ST - 1) * DIV + 3 && lat <= ST * DIV + 2), 1);
    chk("level0_high", lvl_a[0], 1);
    repeat (200) step();
    button[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      step();
      if (rel_a[0]) lat = k;
    end
    chk("release_latency_ok", (lat >= (ST - 1) * DIV + 3 && lat <= ST * DIV + 2), 1);
    chk("level0_low", lvl_a[0], 0);
    repeat (20) step();

    // Glitch: 3 high ticks, 1 low, 3 high -> nothing; a 4th high tick presses.
    npress = 0;
    button[0] = 1'b1;
    repeat (3 * DIV) begin step(); if (prs_a[0]) npress++; end
    button[0] = 1'b0;
    repeat (DIV) begin step(); if (prs_a[0]) npress++; end
    button[0] = 1'b1;
    repeat (3 * DIV) begin step(); if (prs_a[0]) npress++; end
    chk("glitch_no_press", npress, 0);
    repeat (DIV + 5) begin step(); if (prs_a[0]) npress++; end
    chk("glitch_4th_tick_press", npress, 1);
    button[0] = 1'b0;
    repeat (60) step();

    // Long press on channel 1: first hold after HOLD ticks, then every REPA ticks.
    button[1] = 1'b1;
    pc = -1;
    for (int k = 0; k < 60 && pc < 0; k++) begin
      step();
      if (prs_a[1]) pc = cyc;
    end
    chk("long_press_seen", (pc >= 0), 1);
    nh_a = 0; nh_b = 0;
    h[0] = 0; h[1] = 0; h[2] = 0;
    repeat (120 * DIV) begin
      step();
      if (hld_a[1]) begin
        if (nh_a < 3) h[nh_a] = cyc;
        nh_a++;
      end
      if (hld_b[1]) nh_b++;
    end
    chk("first_hold_gap", h[0] - pc, HOLD * DIV);
    chk("repeat_gap_1", h[1] - h[0], REPA * DIV);
    chk("repeat_gap_2", h[2] - h[1], REPA * DIV);
    chk("hold_count_repeat", nh_a, (120 - HOLD) / REPA + 1);
    chk("hold_count_norepeat", nh_b, 1);
    button[1] = 1'b0;
    seen_rel = 0; late = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (rel_a[1]) seen_rel = 1;
      if (seen_rel != 0 && hld_a[1]) late++;
    end
    chk("long_release_seen", seen_rel, 1);
    chk("hold_after_release", late, 0);
    repeat (20) step();

    // Simultaneous press on both channels, then reset in the middle of ARM.
    button = 2'b11;
    pc = -1;
    for (int k = 0; k < 60 && pc < 0; k++) begin
      step();
      if (prs_a != 2'b00) pc = prs_a;
    end
    chk("simultaneous_press", pc, 3);
    repeat (3 * DIV) step();
    pulse_reset(3);
    nhold = 0; pc = -1;
    for (int k = 0; k < 80 && pc < 0; k++) begin
      step();
      if (hld_a != 2'b00 || hld_b != 2'b00) nhold++;
      if (prs_a != 2'b00) pc = prs_a;
    end
    chk("no_hold_after_reset", nhold, 0);
    chk("repress_after_reset", pc, 3);
    repeat (100) step();

    // Randomised segments with different bounce rates and occasional resets.
    for (int seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 3))
        0: rate = 3;
        1: rate = 15;
        2: rate = 60;
        default: rate = 400;
      endcase
      for (int k = 0; k < 500; k++) begin
        if ($urandom_range(0, rate - 1) == 0) button[0] = ~button[0];
        if ($urandom_range(0, rate - 1) == 0) button[1] = ~button[1];
        if ($urandom_range(0, 1999) == 0) pulse_reset($urandom_range(1, 4));
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
